// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// FSM state and access-type encodings, plus a clog2 helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array for the responder.
// Synchronous write, read data follows the index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_raw
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Store the word on the edge the responder commits a write.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata_raw = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: active-low strobes, fixed wait states, stall.
// Optional DMEM_ERR_CHECK_EN flags misaligned/out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              oen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err
);

  localparam int IDX_W = clog2(DEPTH_WORDS);

  state_t            state;
  acc_t              acc_q;
  acc_t              req_type;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_raw;
  logic [3:0]        cnt;
  logic              bad_q;
  logic              req_valid;
  logic              req_bad;
  logic              mem_we;

  // Decode the strobes; a write wins when both are low.
  always_comb begin
    req_type = ACC_NONE;
    if (!wen)      req_type = ACC_WRITE;
    else if (!oen) req_type = ACC_READ;
  end

  assign req_valid = (state == IDLE) && !cen &&
                     (req_type != ACC_NONE);

`ifdef DMEM_ERR_CHECK_EN
  assign req_bad = (addr[1:0] != 2'b00) ||
                   ((addr >> (IDX_W + 2)) != '0);
`else
  assign req_bad = 1'b0;
`endif

  assign stall = req_valid || (state == BUSY);

  assign mem_we = rst_n && (state == BUSY) && (cnt == 4'd0) &&
                  (acc_q == ACC_WRITE) && !bad_q;

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .we        (mem_we),
    .idx       (idx_q),
    .wdata     (wdata_q),
    .rdata_raw (rdata_raw)
  );

  // Access sequencer: latch request, count wait states, complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata   <= '0;
      err     <= 1'b0;
      acc_q   <= ACC_NONE;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
            acc_q   <= req_type;
            bad_q   <= req_bad;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (acc_q == ACC_READ)
              rdata <= bad_q ? '0 : rdata_raw;
            err   <= bad_q;
            state <= DONE;
          end
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Instance u_dut uses 2 wait states, u_fast uses none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen, oen, wen;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err;
  logic        cen2, oen2, wen2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        stall2, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .oen(oen), .wen(wen),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err)
  );

  dmem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .cen(cen2), .oen(oen2), .wen(wen2),
    .addr(addr2), .wdata(wdata2), .rdata(rdata2),
    .stall(stall2), .err(err2)
  );

  // One access on u_dut; starts and ends just after a rising edge.
  task automatic do_access(
    input  logic        is_wr,
    input  logic        is_rd,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          n,
    output logic [31:0] rd,
    output logic        er
  );
    cen = 1'b0; wen = !is_wr; oen = !is_rd;
    addr = a; wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL timeout: stall stuck high at addr %h", a);
        break;
      end
    end
    rd = rdata; er = err;
    cen = 1'b1; wen = 1'b1; oen = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic expect_access(
    input string       name,
    input logic        is_wr,
    input logic        is_rd,
    input logic [31:0] a,
    input logic [31:0] d,
    input int          exp_n,
    input logic [31:0] exp_rd,
    input logic        exp_er
  );
    int n; logic [31:0] rd; logic er;
    do_access(is_wr, is_rd, a, d, n, rd, er);
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, n, exp_n);
    end
    checks++;
    if (rd !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", name, rd, exp_rd);
    end
    checks++;
    if (er !== exp_er) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, er, exp_er);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cen = 1'b1; oen = 1'b1; wen = 1'b1; addr = '0; wdata = '0;
    cen2 = 1'b1; oen2 = 1'b1; wen2 = 1'b1; addr2 = '0; wdata2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err);
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata_fast: got %h want 0", rdata2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      cen = 1'b1; oen = i[0]; wen = i[1];
      addr = 32'h10 + 32'(i * 4);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL idle_stall[%0d]: got %b want 0", i, stall);
      end
      @(posedge clk); #1;
    end
    oen = 1'b1; wen = 1'b1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL idle_rdata: got %h want 0", rdata);
    end
  endtask

  task automatic test_store_load;
    expect_access("store_10", 1, 0, 32'h10, 32'hDEADBEEF, 4, 32'h0, 0);
    expect_access("load_10", 0, 1, 32'h10, 32'h0, 4, 32'hDEADBEEF, 0);
  endtask

  task automatic test_noop;
    expect_access("noop", 0, 0, 32'h10, 32'h55, 0, 32'hDEADBEEF, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL noop_after: stall got %b want 0", stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both_low;
    expect_access("store_24", 1, 0, 32'h24, 32'h7, 4, 32'hDEADBEEF, 0);
    expect_access("load_24", 0, 1, 32'h24, 32'h0, 4, 32'h7, 0);
    expect_access("both_low_20", 1, 1, 32'h20, 32'h5, 4, 32'h7, 0);
    expect_access("load_20", 0, 1, 32'h20, 32'h0, 4, 32'h5, 0);
  endtask

  task automatic test_reset_mid;
    expect_access("pre_store_40", 1, 0, 32'h40, 32'h1111, 4, 32'h5, 0);
    cen = 1'b0; wen = 1'b0; oen = 1'b1;
    addr = 32'h40; wdata = 32'h1234;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    cen = 1'b1; wen = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got %b want 0", stall);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid_rdata: got %h want 0", rdata);
    end
    @(posedge clk); #1;
    expect_access("load_40_after_rst", 0, 1, 32'h40, 32'h0, 4,
                  32'h1111, 0);
  endtask

  task automatic test_wrap;
    expect_access("clear_0", 1, 0, 32'h0, 32'h0, 4, 32'h1111, 0);
`ifdef DMEM_ERR_CHECK_EN
    expect_access("store_400", 1, 0, 32'h400, 32'hA5, 4, 32'h1111, 1);
    expect_access("load_0", 0, 1, 32'h0, 32'h0, 4, 32'h0, 0);
    expect_access("load_11", 0, 1, 32'h11, 32'h0, 4, 32'h0, 1);
`else
    expect_access("store_400", 1, 0, 32'h400, 32'hA5, 4, 32'h1111, 0);
    expect_access("load_0", 0, 1, 32'h0, 32'h0, 4, 32'hA5, 0);
    expect_access("load_13", 0, 1, 32'h13, 32'h0, 4, 32'hDEADBEEF, 0);
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] av [4];
    logic [31:0] dv [4];
    logic        wv [4];
    logic [31:0] ev [4];
    av = '{32'h0, 32'h4, 32'h0, 32'h4};
    dv = '{32'd11, 32'd22, 32'h0, 32'h0};
    wv = '{1'b1, 1'b1, 1'b0, 1'b0};
    ev = '{32'h0, 32'h0, 32'd11, 32'd22};
    for (int k = 0; k < 4; k++) begin
      cen2 = 1'b0; wen2 = !wv[k]; oen2 = wv[k];
      addr2 = av[k]; wdata2 = dv[k];
      @(negedge clk);
      checks++;
      if (stall2 !== 1'b1) begin
        errors++; $display("FAIL b2b_req[%0d]: stall got %b want 1", k, stall2);
      end
      @(negedge clk);
      checks++;
      if (stall2 !== 1'b1) begin
        errors++; $display("FAIL b2b_busy[%0d]: stall got %b want 1", k, stall2);
      end
      @(negedge clk);
      checks++;
      if (stall2 !== 1'b0) begin
        errors++; $display("FAIL b2b_done[%0d]: stall got %b want 0", k, stall2);
      end
      checks++;
      if (rdata2 !== ev[k]) begin
        errors++;
        $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata2, ev[k]);
      end
    end
    cen2 = 1'b1; wen2 = 1'b1; oen2 = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_store_load();
    test_noop();
    test_both_low();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
